i2s_tx_feeder: RTL and testbench
================================

# i2s_tx_feeder

Upstream sample buffer for the I2S transmitter. Accepts stereo sample pairs from the audio processing pipeline over a valid/ready handshake and stores them in a small FIFO. Once per I2S frame it presents one pair on stable, registered outputs that drive the transmitter's `leftChan_i`/`rightChan_i`. It runs entirely in the `sclk_i` domain and is paced by the transmitter's word-select output.

## Interface
- `WIDTH`, default 16: bits per channel sample; must match the transmitter's `WIDTH`.
- `DEPTH`, default 8: number of stereo pairs buffered; power of two, ≥2.

- `sclk_i`  in  1  serial bit clock; all logic on posedge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ws_i`  in  1  word select from the transmitter's `ws_o`; 0 = left half, 1 = right half.
- `sample_valid_i`  in  1  upstream has a pair on `left_i`/`right_i`.
- `sample_ready_o`  out  1  feeder can accept a pair this cycle.
- `left_i`  in  WIDTH  left sample, two's complement.
- `right_i`  in  WIDTH  right sample, two's complement.
- `leftChan_o`  out  WIDTH  registered left sample to the transmitter.
- `rightChan_o`  out  WIDTH  registered right sample to the transmitter.
- `fill_o`  out  $clog2(DEPTH)+1  pairs currently stored, 0..DEPTH.
- `underrun_o`  out  1  one-cycle pulse: a frame fetch found the FIFO empty.

## Operation
- Write: the feeder accepts a pair on a posedge where `sample_valid_i && sample_ready_o`.
- `sample_ready_o = !full && !rst_i`. `full` is registered state, so a pop in the same cycle does not raise ready for that cycle.
- Frame fetch: a registered `ws_q` holds the previous `ws_i`. `fetch = ws_i && !ws_q`, i.e. the rising edge of ws, which marks the start of the right half.
- Fetch with FIFO not empty: the outputs load the head pair, the read pointer advances, and `fill_o` decrements.
- Fetch with FIFO empty: `underrun_o` pulses for 1 cycle. The outputs take the underrun value (see Configuration).
- Simultaneous write and fetch with the FIFO non-empty: both proceed and `fill_o` is unchanged.
- Simultaneous write and fetch with the FIFO empty: the fetch underruns. There is no fall-through. The written pair lands in the FIFO and `fill_o` becomes 1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. `fill_o` saturates at exactly DEPTH, and no write is possible at full.
- Outputs change only on a fetch and are held constant between fetches.

## Timing
- Reset values: `leftChan_o`, `rightChan_o` = 0; `fill_o` = 0; `underrun_o` = 0; `sample_ready_o` = 0 while `rst_i` is high. Pointers = 0; `ws_q` = 1, so there is no spurious fetch out of reset.
- Write latency: a pair accepted at posedge N is visible in `fill_o` after posedge N.
- Output latency: the outputs update on the first posedge where `ws_i` is sampled 1 after being sampled 0.
- The transmitter changes ws on negedge, so the update happens half a cycle after the ws rise. The transmitter samples the outputs WIDTH−1 bit clocks later, at its frame reload, leaving ≥WIDTH−2 cycles of margin.
- Reset asserted mid-operation: all stored pairs are discarded and outputs return to 0 immediately (asynchronous). The first fetch after release requires a fresh 0→1 on `ws_i`.
- Throughput: up to one write per cycle; exactly one read per frame (2·WIDTH cycles).

## Configuration
- `I2S_FEEDER_HOLD_ON_UNDERRUN_EN` defined: on underrun, `leftChan_o`/`rightChan_o` keep their previous values (the last sample repeats).
- Not defined: on underrun, both outputs load 0 (silence).
- `underrun_o` pulses in both builds.

## Structure
- Package `i2s_pkg`:
  - `I2S_WIDTH` default constant (16).
  - `typedef struct packed { logic [WIDTH-1:0] left, right; } stereo_t`, shared with the transmitter wrapper and the receive path.
- Sub-module `i2s_sample_fifo`: synchronous single-clock FIFO of stereo pairs, with `push`, `pop`, `head`, `full`, `empty` and `count` signals, asynchronous active-high reset, and memory inferred as registers.
- The top level holds the ws edge detect, the output registers and the underrun logic.

## Test plan
- Reset, then toggle `ws_i` with no writes. Expect: first ws rise → `underrun_o` = 1 for 1 cycle, outputs 0 (both builds, since the outputs reset to 0), `fill_o` = 0.
- Write 3 pairs (L=0x1111·k, R=0x2222·k, k=1..3) back-to-back, then run frames. Expect: `fill_o` = 3, then successive ws rises present k=1,2,3 in order, `fill_o` steps 2,1,0, and the 4th ws rise underruns.
- Hold `sample_valid_i` = 1 with DEPTH=8 and no ws edges. Expect: exactly 8 accepts, `sample_ready_o` = 0 after the 8th, `fill_o` = 8. Then fire a ws rise with valid still high: a pop on that cycle, a write on the next cycle, and `fill_o` returns to 8.
- With the FIFO empty, fire a write and a ws rise on the same posedge. Expect: `underrun_o` pulses, `fill_o` = 1, and the next ws rise outputs the written pair.
- Present 0xAAAA/0x5555, then underrun. Expect: with `I2S_FEEDER_HOLD_ON_UNDERRUN_EN`, outputs stay 0xAAAA/0x5555; without it, outputs become 0/0.
- Assert `rst_i` mid-stream with `fill_o` = 5 and non-zero outputs. Expect: immediate outputs 0, `fill_o` 0, no fetch on the first cycle after release even if `ws_i` = 1.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample width and the stereo pair layout used
// by the transmitter wrapper, the receive path and the feeder.
package i2s_pkg;

    localparam int I2S_WIDTH = 16;

    typedef struct packed {
        logic [I2S_WIDTH-1:0] left;
        logic [I2S_WIDTH-1:0] right;
    } stereo_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Single-clock FIFO of stereo pairs. Register-based storage, power-of-two depth,
// and an occupancy count that saturates at DEPTH.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 2 * I2S_WIDTH,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty,
    output logic [CW-1:0]         count
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Sample buffer in front of the I2S transmitter: one pair fetched per ws rise.
// Define I2S_FEEDER_HOLD_ON_UNDERRUN_EN to repeat the last pair on underrun.
module i2s_tx_feeder
    import i2s_pkg::*;
#(
    parameter int WIDTH = I2S_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     sclk_i,
    input  logic                     rst_i,
    input  logic                     ws_i,
    input  logic                     sample_valid_i,
    output logic                     sample_ready_o,
    input  logic [WIDTH-1:0]         left_i,
    input  logic [WIDTH-1:0]         right_i,
    output logic [WIDTH-1:0]         leftChan_o,
    output logic [WIDTH-1:0]         rightChan_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     underrun_o
);

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } pair_t;

    pair_t wr_pair;
    pair_t head_pair;
    logic  ws_q;
    logic  fetch;
    logic  full;
    logic  empty;
    logic  push;
    logic  pop;

    assign wr_pair        = '{left: left_i, right: right_i};
    assign sample_ready_o = !full && !rst_i;
    assign push           = sample_valid_i && sample_ready_o;
    assign fetch          = ws_i && !ws_q;
    assign pop            = fetch && !empty;

    i2s_sample_fifo #(
        .DATA_WIDTH (2 * WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (sclk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (wr_pair),
        .head  (head_pair),
        .full  (full),
        .empty (empty),
        .count (fill_o)
    );

    // ws_q resets high so a ws_i already high at release is not seen as a rise.
    always_ff @(posedge sclk_i or posedge rst_i) begin
        if (rst_i) begin
            ws_q        <= 1'b1;
            leftChan_o  <= '0;
            rightChan_o <= '0;
            underrun_o  <= 1'b0;
        end else begin
            ws_q       <= ws_i;
            underrun_o <= fetch && empty;
            if (pop) begin
                leftChan_o  <= head_pair.left;
                rightChan_o <= head_pair.right;
            end
`ifndef I2S_FEEDER_HOLD_ON_UNDERRUN_EN
            else if (fetch) begin
                leftChan_o  <= '0;
                rightChan_o <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Directed bench for i2s_tx_feeder with a queue scoreboard of accepted pairs.
module tb_i2s_tx_feeder;
    import i2s_pkg::*;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int FW = $clog2(D) + 1;

    logic          sclk = 1'b0;
    logic          rst = 1'b1;
    logic          ws = 1'b1;
    logic          valid = 1'b0;
    logic [W-1:0]  l_in = '0;
    logic [W-1:0]  r_in = '0;
    logic          ready;
    logic [W-1:0]  l_out;
    logic [W-1:0]  r_out;
    logic [FW-1:0] fill;
    logic          und;

    int checks = 0;
    int errors = 0;

    logic [2*W-1:0] sb [$];
    int             mfill = 0;
    logic           mws_q = 1'b1;
    logic [W-1:0]   ml = '0;
    logic [W-1:0]   mr = '0;
    logic           mund = 1'b0;

    i2s_tx_feeder #(.WIDTH(W), .DEPTH(D)) dut (
        .sclk_i         (sclk),
        .rst_i          (rst),
        .ws_i           (ws),
        .sample_valid_i (valid),
        .sample_ready_o (ready),
        .left_i         (l_in),
        .right_i        (r_in),
        .leftChan_o     (l_out),
        .rightChan_o    (r_out),
        .fill_o         (fill),
        .underrun_o     (und)
    );

    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mfill = 0;
        mws_q = 1'b1;
        ml    = '0;
        mr    = '0;
        mund  = 1'b0;
    endtask

    // One clock: predict from the inputs held across the edge, then compare.
    task automatic step();
        logic fetch;
        logic acc;
        fetch = ws && !mws_q && !rst;
        acc   = valid && (mfill < D) && !rst;
        @(posedge sclk);
        if (rst) begin
            model_reset();
        end else begin
            mws_q = ws;
            mund  = 1'b0;
            if (fetch) begin
                if (sb.size() > 0) begin
                    {ml, mr} = sb.pop_front();
                    mfill--;
                end else begin
                    mund = 1'b1;
`ifndef I2S_FEEDER_HOLD_ON_UNDERRUN_EN
                    ml = '0;
                    mr = '0;
`endif
                end
            end
            if (acc) begin
                sb.push_back({l_in, r_in});
                mfill++;
            end
        end
        #1;
        check("fill", 32'(fill), 32'(mfill));
        check("underrun", 32'(und), 32'(mund));
        check("left", 32'(l_out), 32'(ml));
        check("right", 32'(r_out), 32'(mr));
        check("ready", 32'(ready), 32'((mfill < D) && !rst));
    endtask

    task automatic ws_rise();
        ws = 1'b0;
        step();
        ws = 1'b1;
        step();
    endtask

    task automatic write_pair(input logic [W-1:0] l, input logic [W-1:0] r);
        valid = 1'b1;
        l_in  = l;
        r_in  = r;
        step();
        valid = 1'b0;
    endtask

    initial begin
        // Reset values
        step();
        step();
        check("rst_fill", 32'(fill), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_left", 32'(l_out), 0);
        rst = 1'b0;
        step();
        check("no_fetch_after_release", 32'(und), 0);

        // Toggle ws with no writes: first rise underruns for one cycle
        ws_rise();
        check("first_underrun", 32'(und), 1);
        check("first_underrun_left", 32'(l_out), 0);
        step();
        check("underrun_one_cycle", 32'(und), 0);

        // Three pairs then frames
        for (int k = 1; k <= 3; k++) write_pair(W'(16'h1111 * k), W'(16'h2222 * k));
        check("fill_three", 32'(fill), 3);
        for (int k = 1; k <= 3; k++) begin
            ws_rise();
            check("seq_left", 32'(l_out), 32'(16'h1111 * k));
            check("seq_right", 32'(r_out), 32'(16'h2222 * k));
            check("seq_fill", 32'(fill), 32'(3 - k));
            repeat (4) step();
        end
        ws_rise();
        check("fourth_underrun", 32'(und), 1);

        // Fill to DEPTH with valid held high and no ws edges
        valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            l_in = W'(16'h0100 + i);
            r_in = W'(16'h0200 + i);
            step();
        end
        check("full_fill", 32'(fill), 8);
        check("full_ready", 32'(ready), 0);
        ws = 1'b0;
        step();
        ws = 1'b1;
        step();
        check("full_pop_fill", 32'(fill), 7);
        check("full_pop_left", 32'(l_out), 32'h0100);
        step();
        check("refill", 32'(fill), 8);
        valid = 1'b0;
        for (int i = 0; i < 8; i++) ws_rise();
        check("drained", 32'(fill), 0);

        // Write and fetch on the same posedge with the FIFO empty
        ws = 1'b0;
        step();
        ws    = 1'b1;
        valid = 1'b1;
        l_in  = 16'hBEEF;
        r_in  = 16'hCAFE;
        step();
        valid = 1'b0;
        check("simul_underrun", 32'(und), 1);
        check("simul_fill", 32'(fill), 1);
        ws_rise();
        check("simul_left", 32'(l_out), 32'hBEEF);
        check("simul_right", 32'(r_out), 32'hCAFE);

        // Underrun value
        write_pair(16'hAAAA, 16'h5555);
        ws_rise();
        check("pre_underrun_left", 32'(l_out), 32'hAAAA);
        ws_rise();
        check("underrun_pulse", 32'(und), 1);
`ifdef I2S_FEEDER_HOLD_ON_UNDERRUN_EN
        check("hold_left", 32'(l_out), 32'hAAAA);
        check("hold_right", 32'(r_out), 32'h5555);
`else
        check("silence_left", 32'(l_out), 0);
        check("silence_right", 32'(r_out), 0);
`endif

        // Mid-stream reset
        for (int i = 1; i <= 6; i++) write_pair(W'(16'h0A00 + i), W'(16'h0B00 + i));
        ws_rise();
        check("pre_reset_fill", 32'(fill), 5);
        check("pre_reset_left", 32'(l_out), 32'h0A01);
        #2;
        rst = 1'b1;
        #1;
        check("async_left", 32'(l_out), 0);
        check("async_right", 32'(r_out), 0);
        check("async_fill", 32'(fill), 0);
        check("async_ready", 32'(ready), 0);
        model_reset();
        step();
        rst = 1'b0;
        step();
        check("post_reset_no_fetch", 32'(und), 0);
        check("post_reset_left", 32'(l_out), 0);
        ws_rise();
        check("post_reset_underrun", 32'(und), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
